// File: rtl/id_ex_reg_pkg.sv
// Shared encodings for the ID/EX pipeline register: control codes and the
// bubble value loaded into each control field on flush or reset.
package id_ex_reg_pkg;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [2:0] BR_NONE    = 3'd0;
  localparam logic       B_SEL_RD2  = 1'b0;
  localparam logic       B_SEL_EXT  = 1'b1;

  localparam logic [1:0] WD_SEL_ALU = 2'd0;
  localparam logic [1:0] WD_SEL_RAM = 2'd1;
  localparam logic [1:0] WD_SEL_PC4 = 2'd2;
  localparam logic [1:0] WD_SEL_EXT = 2'd3;

  // Bubble pattern per control field: a bubble must never write state.
  localparam logic       BUB_VALID  = 1'b0;
  localparam logic       BUB_RF_WE  = 1'b0;
  localparam logic       BUB_RAM_WE = 1'b0;
  localparam logic [2:0] BUB_BR_OP  = BR_NONE;
  localparam logic [3:0] BUB_ALU_OP = ALU_ADD;
  localparam logic       BUB_B_SEL  = B_SEL_RD2;
  localparam logic [1:0] BUB_WD_SEL = WD_SEL_ALU;

endpackage

// File: rtl/id_ex_reg_field.sv
// Generic pipeline field register: rst > flush > stall > load, with a
// per-instance bubble value. Reusable for later pipeline registers.
module pipe_field_reg #(
  parameter int             W      = 1,
  parameter logic [W-1:0]   BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (flush)
      q <= BUBBLE;
    else if (!stall)
      q <= d;
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register built from pipe_field_reg instances.
// Optional perf counters (bubble_cnt, stall_cnt) with ID_EX_PERF_CNT_EN.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [3:0]      id_alu_op,
  input  logic            id_b_sel,
  input  logic [2:0]      id_br_op,
  input  logic [XLEN-1:0] id_A,
  input  logic [XLEN-1:0] id_sext_ext,
  input  logic [XLEN-1:0] id_rf_rD2,
  input  logic [RD_W-1:0] id_rd,
  input  logic            id_rf_we,
  input  logic [1:0]      id_wd_sel,
  input  logic            id_ram_we,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [3:0]      ex_alu_op,
  output logic            ex_b_sel,
  output logic [2:0]      ex_br_op,
  output logic [XLEN-1:0] ex_A,
  output logic [XLEN-1:0] ex_sext_ext,
  output logic [XLEN-1:0] ex_rf_rD2,
  output logic [RD_W-1:0] ex_rd,
  output logic            ex_rf_we,
  output logic [1:0]      ex_wd_sel,
  output logic            ex_ram_we
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  // A non-valid slot still carries its fields but must have no side effects.
  logic       rf_we_g;
  logic       ram_we_g;
  logic [2:0] br_op_g;

  assign rf_we_g  = id_valid & id_rf_we;
  assign ram_we_g = id_valid & id_ram_we;
  assign br_op_g  = id_valid ? id_br_op : BR_NONE;

  pipe_field_reg #(.W(1), .BUBBLE(BUB_VALID)) u_valid (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .d(id_valid), .q(ex_valid));
  pipe_field_reg #(.W(XLEN)) u_pc (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .d(id_pc), .q(ex_pc));
  pipe_field_reg #(.W(4), .BUBBLE(BUB_ALU_OP)) u_alu_op (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .d(id_alu_op), .q(ex_alu_op));
  pipe_field_reg #(.W(1), .BUBBLE(BUB_B_SEL)) u_b_sel (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .d(id_b_sel), .q(ex_b_sel));
  pipe_field_reg #(.W(3), .BUBBLE(BUB_BR_OP)) u_br_op (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .d(br_op_g), .q(ex_br_op));
  pipe_field_reg #(.W(XLEN)) u_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .d(id_A), .q(ex_A));
  pipe_field_reg #(.W(XLEN)) u_sext_ext (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .d(id_sext_ext), .q(ex_sext_ext));
  pipe_field_reg #(.W(XLEN)) u_rf_rd2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .d(id_rf_rD2), .q(ex_rf_rD2));
  pipe_field_reg #(.W(RD_W)) u_rd (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .d(id_rd), .q(ex_rd));
  pipe_field_reg #(.W(1), .BUBBLE(BUB_RF_WE)) u_rf_we (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .d(rf_we_g), .q(ex_rf_we));
  pipe_field_reg #(.W(2), .BUBBLE(BUB_WD_SEL)) u_wd_sel (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .d(id_wd_sel), .q(ex_wd_sel));
  pipe_field_reg #(.W(1), .BUBBLE(BUB_RAM_WE)) u_ram_we (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .d(ram_we_g), .q(ex_ram_we));

`ifdef ID_EX_PERF_CNT_EN
  logic bubble_ev;
  logic stall_ev;

  assign bubble_ev = flush | (~stall & ~id_valid);
  assign stall_ev  = stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (bubble_ev && bubble_cnt != 32'hFFFF_FFFF)
        bubble_cnt <= bubble_cnt + 32'd1;
      if (stall_ev && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
